// File: rtl/shift_rows_if.sv
// shift_rows_if: valid/ready beat bus into and out of the ShiftRows pipeline
interface shift_rows_if #(
  parameter int NUM_STATES = 4,
  parameter int TAG_W      = 8
);
  logic                      in_valid;
  logic                      in_ready;
  logic                      in_inv;
  logic [TAG_W-1:0]          in_tag;
  logic [128*NUM_STATES-1:0] in_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [TAG_W-1:0]          out_tag;
  logic [128*NUM_STATES-1:0] out_data;
  modport master (
    output in_valid, in_inv, in_tag, in_data, out_ready,
    input  in_ready, out_valid, out_tag, out_data
  );
  modport slave (
    input  in_valid, in_inv, in_tag, in_data, out_ready,
    output in_ready, out_valid, out_tag, out_data
  );
endinterface

// File: rtl/shift_rows_pipe.sv
// shift_rows_pipe: elastic pipelined ShiftRows/InvShiftRows over NUM_STATES AES states
module shift_rows_pipe #(
  parameter int NUM_STATES = 4,
  parameter int STAGES     = 2,
  parameter int TAG_W      = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  output logic         busy,
  shift_rows_if.slave  sr
);
  localparam int W = 128 * NUM_STATES;
  // Row r is rotated by r bytes; the inverse reads from the opposite direction.
  function automatic logic [127:0] perm(input logic [127:0] s, input logic inv);
    perm = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        perm[127-32*r-8*c -: 8] = s[127-32*r-8*((inv ? c + 4 - r : c + r) % 4) -: 8];
  endfunction
  logic [STAGES-1:0] v;
  logic [STAGES-1:0] en;
  logic [STAGES:0]   ld;
  logic [W-1:0]      pd;
  logic [W-1:0]      d  [STAGES];
  logic [W-1:0]      nd [STAGES];
  logic [TAG_W-1:0]  t  [STAGES];
  logic [TAG_W-1:0]  nt [STAGES];
  for (genvar s = 0; s < NUM_STATES; s++) begin : g_lane
    assign pd[128*s +: 128] = perm(sr.in_data[128*s +: 128], sr.in_inv);
  end
  assign nd[0] = pd;
  assign nt[0] = sr.in_tag;
  for (genvar g = 1; g < STAGES; g++) begin : g_fwd
    assign nd[g] = d[g-1];
    assign nt[g] = t[g-1];
  end
  // Ready ripples back from the consumer: ld[k+1] means stage k hands its beat on.
  always_comb begin
    ld = '0;
    en = '0;
    ld[STAGES] = v[STAGES-1] && sr.out_ready;
    for (int k = STAGES - 1; k > 0; k--) begin
      en[k] = !v[k] || ld[k+1];
      ld[k] = v[k-1] && en[k];
    end
    en[0] = !v[0] || ld[1];
    ld[0] = sr.in_valid && !flush && en[0];
  end
  assign sr.in_ready  = !flush && en[0];
  assign sr.out_valid = v[STAGES-1];
  assign sr.out_data  = d[STAGES-1];
  assign sr.out_tag   = t[STAGES-1];
  assign busy         = |v;
  // Stage registers: valid tracks occupancy, payload moves only on a load.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v <= '0;
      for (int k = 0; k < STAGES; k++) begin
        d[k] <= '0;
        t[k] <= '0;
      end
    end else
      for (int k = 0; k < STAGES; k++) begin
        v[k] <= !flush && (ld[k] || (v[k] && !ld[k+1]));
        if (ld[k]) begin
          d[k] <= nd[k];
          t[k] <= nt[k];
        end
      end
endmodule

// File: tb/tb_shift_rows_pipe.sv
// tb_shift_rows_pipe: directed checks of the ShiftRows pipeline
module tb_shift_rows_pipe;
  localparam int NS = 4;
  localparam int ST = 2;
  localparam int TW = 8;
  localparam int W  = 128 * NS;
  localparam logic [127:0] FA = 128'h87F24D97_EC6E4C90_4AC346E7_8CD895A6;
  localparam logic [127:0] FB = 128'h87F24D97_6E4C90EC_46E74AC3_A68CD895;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic busy;
  int n = 0;
  int errs = 0;
  shift_rows_if #(.NUM_STATES(NS), .TAG_W(TW)) sr();
  shift_rows_pipe #(.NUM_STATES(NS), .STAGES(ST), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .busy(busy), .sr(sr)
  );
  always #5 clk = ~clk;
  // Reference: treat each row as a 32-bit word and rotate it by whole bytes.
  function automatic logic [W-1:0] mdl(input logic [W-1:0] x, input logic inv);
    logic [W-1:0] o;
    logic [31:0] row;
    int sh;
    o = '0;
    for (int s = 0; s < NS; s++)
      for (int r = 0; r < 4; r++) begin
        row = x[128*s+127-32*r -: 32];
        sh = 8 * r;
        o[128*s+127-32*r -: 32] = inv ? ((row >> sh) | (row << (32 - sh))) : ((row << sh) | (row >> (32 - sh)));
      end
    return o;
  endfunction
  function automatic logic [W-1:0] rnd_beat(input logic [127:0] l0);
    logic [W-1:0] b;
    b = '0;
    b[127:0] = l0;
    for (int s = 1; s < NS; s++) b[128*s +: 128] = {$urandom(), $urandom(), $urandom(), $urandom()};
    return b;
  endfunction
  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction
  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic vld, input logic inv, input logic [TW-1:0] tag, input logic [W-1:0] data);
    sr.in_valid = vld;
    sr.in_inv   = inv;
    sr.in_tag   = tag;
    sr.in_data  = data;
  endtask
  logic [W-1:0] x, y, hold;
  logic [W-1:0] q [8];
  initial begin
    drive(1'b0, 1'b0, '0, '0);
    sr.out_ready = 1'b1;
    #12;
    chk("rst_out_valid", W'(sr.out_valid), W'(0));
    chk("rst_out_data", sr.out_data, W'(0));
    chk("rst_out_tag", W'(sr.out_tag), W'(0));
    chk("rst_busy", W'(busy), W'(0));
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", W'(sr.in_ready), W'(1));
    step();
    x = rnd_beat(FA);
    drive(1'b1, 1'b0, 8'hA5, x);
    step();
    sr.in_valid = 1'b0;
    chk("fwd_lat_early", W'(sr.out_valid), W'(0));
    chk("fwd_busy", W'(busy), W'(1));
    step();
    chk("fwd_valid", W'(sr.out_valid), W'(1));
    chk("fwd_lane0", W'(sr.out_data[127:0]), W'(FB));
    chk("fwd_data", sr.out_data, mdl(x, 1'b0));
    chk("fwd_tag", W'(sr.out_tag), W'(8'hA5));
    step();
    chk("fwd_idle", W'(busy), W'(0));
    x = rnd_beat(FB);
    drive(1'b1, 1'b1, 8'h5A, x);
    step();
    sr.in_valid = 1'b0;
    step();
    chk("inv_valid", W'(sr.out_valid), W'(1));
    chk("inv_lane0", W'(sr.out_data[127:0]), W'(FA));
    chk("inv_data", sr.out_data, mdl(x, 1'b1));
    chk("inv_tag", W'(sr.out_tag), W'(8'h5A));
    step();
    for (int i = 0; i < 9; i++) begin
      if (i < 8) begin
        q[i] = rnd_beat(rnd128());
        drive(1'b1, i[0], 8'(i), q[i]);
        chk("stream_in_ready", W'(sr.in_ready), W'(1));
      end else sr.in_valid = 1'b0;
      step();
      if (i > 0) begin
        chk("stream_valid", W'(sr.out_valid), W'(1));
        chk("stream_tag", W'(sr.out_tag), W'(i - 1));
        chk("stream_data", sr.out_data, mdl(q[i-1], 1'(i - 1)));
      end
    end
    step();
    chk("stream_idle", W'(busy), W'(0));
    sr.out_ready = 1'b0;
    x = rnd_beat(rnd128());
    y = rnd_beat(rnd128());
    drive(1'b1, 1'b0, 8'd20, x);
    chk("bp_ready0", W'(sr.in_ready), W'(1));
    step();
    drive(1'b1, 1'b1, 8'd21, y);
    chk("bp_ready1", W'(sr.in_ready), W'(1));
    step();
    drive(1'b1, 1'b0, 8'd22, rnd_beat(rnd128()));
    chk("bp_full", W'(sr.in_ready), W'(0));
    chk("bp_head", sr.out_data, mdl(x, 1'b0));
    hold = sr.out_data;
    step();
    chk("bp_still_full", W'(sr.in_ready), W'(0));
    chk("bp_stable_data", sr.out_data, hold);
    chk("bp_stable_tag", W'(sr.out_tag), W'(20));
    chk("bp_stable_valid", W'(sr.out_valid), W'(1));
    sr.out_ready = 1'b1;
    #1;
    chk("bp_ready_passthru", W'(sr.in_ready), W'(1));
    sr.in_valid = 1'b0;
    step();
    chk("bp_drain_valid", W'(sr.out_valid), W'(1));
    chk("bp_drain_tag", W'(sr.out_tag), W'(21));
    chk("bp_drain_data", sr.out_data, mdl(y, 1'b1));
    step();
    chk("bp_drain_done", W'(sr.out_valid), W'(0));
    chk("bp_idle", W'(busy), W'(0));
    drive(1'b1, 1'b0, 8'd30, rnd_beat(rnd128()));
    step();
    drive(1'b1, 1'b1, 8'd31, rnd_beat(rnd128()));
    step();
    drive(1'b1, 1'b0, 8'd32, rnd_beat(rnd128()));
    flush = 1'b1;
    #1;
    chk("flush_in_ready", W'(sr.in_ready), W'(0));
    chk("flush_busy_before", W'(busy), W'(1));
    step();
    flush = 1'b0;
    sr.in_valid = 1'b0;
    chk("flush_busy", W'(busy), W'(0));
    chk("flush_valid", W'(sr.out_valid), W'(0));
    step();
    chk("flush_no_accept", W'(sr.out_valid), W'(0));
    chk("flush_still_idle", W'(busy), W'(0));
    drive(1'b1, 1'b0, 8'd40, rnd_beat(rnd128()));
    step();
    drive(1'b1, 1'b1, 8'd41, rnd_beat(rnd128()));
    step();
    sr.in_valid = 1'b0;
    sr.out_ready = 1'b0;
    chk("pre_rst_valid", W'(sr.out_valid), W'(1));
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", W'(sr.out_valid), W'(0));
    chk("mid_rst_data", sr.out_data, W'(0));
    chk("mid_rst_tag", W'(sr.out_tag), W'(0));
    chk("mid_rst_busy", W'(busy), W'(0));
    #2 rst_n = 1'b1;
    sr.out_ready = 1'b1;
    x = rnd_beat(rnd128());
    drive(1'b1, 1'b1, 8'd50, x);
    step();
    sr.in_valid = 1'b0;
    chk("post_rst_early", W'(sr.out_valid), W'(0));
    step();
    chk("post_rst_valid", W'(sr.out_valid), W'(1));
    chk("post_rst_data", sr.out_data, mdl(x, 1'b1));
    chk("post_rst_tag", W'(sr.out_tag), W'(50));
    step();
    $display("== %0d vectors applied, %0d miscompares ==", n, errs);
    $finish;
  end
endmodule
